// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared configuration for the fetch controller slice: the address
// width, an all-zero word, and a helper that sizes occupancy counters.
package pc_fetch_ctrl_pkg;

  localparam int AddrLen = 32;
  localparam logic [AddrLen-1:0] ZERO_WORD = '0;

  // An occupancy counter has to represent 0..depth inclusive, so it
  // needs one more bit than the pointers.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_tag_fifo.sv
// Small circular queue that holds {pc, epoch} tags for fetches that are
// in flight. The head entry is always visible on data_o, so a consumer
// can inspect it and pop it in the same cycle. DEPTH must be a power of
// two, which lets the pointers wrap by natural overflow.
module pc_tag_fifo
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = cnt_width(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full queue or a pop from an empty one is ignored.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and occupancy update; push and pop together leave the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; the contents need no reset because count guards them.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch PC controller. It issues sequential fetch addresses,
// keeps at most MAX_OUT fetches outstanding, and tags each fetch with a
// redirect epoch. Responses return in order; a response whose tag does
// not match the current epoch (or that coincides with a redirect) belongs
// to a flushed path and is dropped without a pc_valid_o pulse.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int                   ADDR_LEN  = AddrLen,
  parameter logic [ADDR_LEN-1:0] RESET_VEC = ADDR_LEN'(ZERO_WORD),
  parameter int                   STEP      = 4,
  parameter int                   MAX_OUT   = 2,
  parameter int                   EPOCH_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [ADDR_LEN-1:0] redirect_pc_i,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  output logic [ADDR_LEN-1:0] req_pc_o,
  output logic [EPOCH_W-1:0]  req_epoch_o,
  input  logic                resp_valid_i,
  output logic                pc_valid_o,
  output logic [ADDR_LEN-1:0] pc_o
);

  localparam int TagW = ADDR_LEN + EPOCH_W;

  logic [ADDR_LEN-1:0] pc_q, pc_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic [ADDR_LEN-1:0] out_pc_q, out_pc_d;
  logic                out_valid_q, out_valid_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic [TagW-1:0]     fifo_head;
  logic [ADDR_LEN-1:0] head_pc;
  logic [EPOCH_W-1:0]  head_epoch;
  logic                handshake;
  logic                pop;
  logic                live;

  assign head_pc    = fifo_head[EPOCH_W +: ADDR_LEN];
  assign head_epoch = fifo_head[EPOCH_W-1:0];

  // Request side: a redirect always wins over issuing, and the queue
  // bounds how many fetches can be in flight.
  assign req_valid_o = rdy & ~rst & ~stall_i & ~redirect_i & ~fifo_full;
  assign req_pc_o    = pc_q;
  assign req_epoch_o = epoch_q;
  assign handshake   = req_valid_o & req_ready_i;

  // Response side: every response retires the oldest entry, but only one
  // from the current epoch, not racing a redirect, reports a completed PC.
  assign pop  = rdy & resp_valid_i & ~fifo_empty;
  assign live = pop & (head_epoch == epoch_q) & ~redirect_i;

  pc_tag_fifo #(
    .WIDTH (TagW),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (handshake),
    .pop_i   (pop),
    .data_i  ({pc_q, epoch_q}),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next fetch PC, epoch and completion report; everything holds while rdy is low.
  always_comb begin
    pc_d        = pc_q;
    epoch_d     = epoch_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;
    if (rdy) begin
      if (redirect_i) begin
        pc_d    = redirect_pc_i;
        epoch_d = epoch_q + EPOCH_W'(1);
      end else if (handshake) begin
        pc_d = pc_q + ADDR_LEN'(STEP);
      end
      out_valid_d = live;
      if (live) out_pc_d = head_pc;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VEC;
      epoch_q     <= '0;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pc_valid_o = out_valid_q;
  assign pc_o       = out_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl with default parameters
// (32-bit PC, reset vector 0, step 4, two outstanding, 2-bit epoch).
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_pc_o;
  logic [1:0]  req_epoch_o;
  logic        resp_valid_i;
  logic        pc_valid_o;
  logic [31:0] pc_o;

  int tests_run = 0;
  int tests_failed = 0;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_pc_o      (req_pc_o),
    .req_epoch_o   (req_epoch_o),
    .resp_valid_i  (resp_valid_i),
    .pc_valid_o    (pc_valid_o),
    .pc_o          (pc_o)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance past one rising edge; inputs change and outputs are sampled 2 ns later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; req_ready_i = 1'b0; resp_valid_i = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; req_ready_i = 1'b0; resp_valid_i = 1'b0;
    #1;
    tests_run++; if (req_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req_valid_in_rst: got %b expected 0", req_valid_o); end
    cyc();
    rst = 1'b0;
    #1;
    tests_run++; if (req_pc_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pc: got %h expected 00000000", req_pc_o); end
    tests_run++; if (req_epoch_o !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_epoch: got %0d expected 0", req_epoch_o); end
    tests_run++; if (pc_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pc_valid: got %b expected 0", pc_valid_o); end
    tests_run++; if (pc_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pc_o: got %h expected 00000000", pc_o); end
    tests_run++; if (req_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_valid_after: got %b expected 1", req_valid_o); end
  endtask

  task automatic test_stall();
    do_reset();
    req_ready_i = 1'b1; stall_i = 1'b1;
    #1;
    tests_run++; if (req_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_req_valid: got %b expected 0", req_valid_o); end
    cyc();
    tests_run++; if (req_pc_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL stall_pc_hold: got %h expected 00000000", req_pc_o); end
    stall_i = 1'b0;
    #1;
    tests_run++; if (req_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_release: got %b expected 1", req_valid_o); end
    req_ready_i = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req_ready_i = 1'b1;
      resp_valid_i = (k >= 1);
      #1;
      tests_run++; if (req_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL stream_req_valid k=%0d: got %b expected 1", k, req_valid_o); end
      tests_run++; if (req_pc_o !== 32'(4 * k)) begin tests_failed++; $display("[TB] FAIL stream_req_pc k=%0d: got %h expected %h", k, req_pc_o, 32'(4 * k)); end
      cyc();
      tests_run++; if (pc_valid_o !== (k >= 1)) begin tests_failed++; $display("[TB] FAIL stream_pc_valid k=%0d: got %b expected %b", k, pc_valid_o, (k >= 1)); end
      if (k >= 1) begin
        tests_run++; if (pc_o !== 32'(4 * (k - 1))) begin tests_failed++; $display("[TB] FAIL stream_pc_o k=%0d: got %h expected %h", k, pc_o, 32'(4 * (k - 1))); end
      end
    end
    req_ready_i = 1'b0; resp_valid_i = 1'b1;
    cyc();
    tests_run++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h14) begin tests_failed++; $display("[TB] FAIL stream_drain: got valid=%b pc=%h expected valid=1 pc=00000014", pc_valid_o, pc_o); end
    resp_valid_i = 1'b0;
    cyc();
    tests_run++; if (pc_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL stream_pulse_end: got %b expected 0", pc_valid_o); end
    tests_run++; if (pc_o !== 32'h14) begin tests_failed++; $display("[TB] FAIL stream_pc_o_hold: got %h expected 00000014", pc_o); end
    tests_run++; if (req_pc_o !== 32'h18) begin tests_failed++; $display("[TB] FAIL stream_next_pc: got %h expected 00000018", req_pc_o); end
  endtask

  task automatic test_redirect();
    do_reset();
    req_ready_i = 1'b1;
    cyc();
    cyc();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    #1;
    tests_run++; if (req_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL redir_no_issue: got %b expected 0", req_valid_o); end
    cyc();
    redirect_i = 1'b0; resp_valid_i = 1'b1;
    #1;
    tests_run++; if (req_pc_o !== 32'h100) begin tests_failed++; $display("[TB] FAIL redir_pc: got %h expected 00000100", req_pc_o); end
    tests_run++; if (req_epoch_o !== 2'd1) begin tests_failed++; $display("[TB] FAIL redir_epoch: got %0d expected 1", req_epoch_o); end
    tests_run++; if (req_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL redir_full: got %b expected 0", req_valid_o); end
    cyc();
    tests_run++; if (pc_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL redir_drop0: got %b expected 0", pc_valid_o); end
    tests_run++; if (req_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL redir_slot_free: got %b expected 1", req_valid_o); end
    cyc();
    tests_run++; if (pc_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL redir_drop4: got %b expected 0", pc_valid_o); end
    req_ready_i = 1'b0;
    cyc();
    tests_run++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h100) begin tests_failed++; $display("[TB] FAIL redir_first_live: got valid=%b pc=%h expected valid=1 pc=00000100", pc_valid_o, pc_o); end
    resp_valid_i = 1'b0;
  endtask

  task automatic test_max_outstanding();
    do_reset();
    req_ready_i = 1'b1;
    cyc();
    cyc();
    tests_run++; if (req_valid_o !== 1'b0 || req_pc_o !== 32'h8) begin tests_failed++; $display("[TB] FAIL max_full: got valid=%b pc=%h expected valid=0 pc=00000008", req_valid_o, req_pc_o); end
    cyc();
    cyc();
    tests_run++; if (req_valid_o !== 1'b0 || req_pc_o !== 32'h8) begin tests_failed++; $display("[TB] FAIL max_stays_full: got valid=%b pc=%h expected valid=0 pc=00000008", req_valid_o, req_pc_o); end
    resp_valid_i = 1'b1;
    cyc();
    tests_run++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL max_resp: got valid=%b pc=%h expected valid=1 pc=00000000", pc_valid_o, pc_o); end
    resp_valid_i = 1'b0;
    #1;
    tests_run++; if (req_valid_o !== 1'b1 || req_pc_o !== 32'h8) begin tests_failed++; $display("[TB] FAIL max_reissue: got valid=%b pc=%h expected valid=1 pc=00000008", req_valid_o, req_pc_o); end
    cyc();
    tests_run++; if (req_valid_o !== 1'b0 || req_pc_o !== 32'hC) begin tests_failed++; $display("[TB] FAIL max_refull: got valid=%b pc=%h expected valid=0 pc=0000000c", req_valid_o, req_pc_o); end
    req_ready_i = 1'b0;
  endtask

  task automatic test_redirect_resp();
    do_reset();
    req_ready_i = 1'b1;
    cyc();
    req_ready_i = 1'b0; resp_valid_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    cyc();
    tests_run++; if (pc_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_dropped: got %b expected 0", pc_valid_o); end
    tests_run++; if (req_epoch_o !== 2'd1 || req_pc_o !== 32'h200) begin tests_failed++; $display("[TB] FAIL rr_redirect: got epoch=%0d pc=%h expected epoch=1 pc=00000200", req_epoch_o, req_pc_o); end
    resp_valid_i = 1'b0; redirect_i = 1'b0; req_ready_i = 1'b1;
    #1;
    tests_run++; if (req_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL rr_issue0: got %b expected 1", req_valid_o); end
    cyc();
    tests_run++; if (req_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL rr_count_decremented: got %b expected 1", req_valid_o); end
    cyc();
    tests_run++; if (req_valid_o !== 1'b0 || req_pc_o !== 32'h208) begin tests_failed++; $display("[TB] FAIL rr_full: got valid=%b pc=%h expected valid=0 pc=00000208", req_valid_o, req_pc_o); end
    req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      redirect_i = 1'b1; redirect_pc_i = 32'h300 + 32'(i) * 32'h100;
      cyc();
      tests_run++; if (req_epoch_o !== 2'((i + 2) % 4)) begin tests_failed++; $display("[TB] FAIL rr_epoch i=%0d: got %0d expected %0d", i, req_epoch_o, (i + 2) % 4); end
    end
    redirect_i = 1'b0;
    tests_run++; if (req_pc_o !== 32'h500) begin tests_failed++; $display("[TB] FAIL rr_last_pc: got %h expected 00000500", req_pc_o); end
    resp_valid_i = 1'b1;
    cyc();
    tests_run++; if (pc_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_stale_a: got %b expected 0", pc_valid_o); end
    cyc();
    tests_run++; if (pc_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_stale_b: got %b expected 0", pc_valid_o); end
    resp_valid_i = 1'b0; req_ready_i = 1'b1;
    cyc();
    req_ready_i = 1'b0; resp_valid_i = 1'b1;
    cyc();
    tests_run++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h500) begin tests_failed++; $display("[TB] FAIL rr_wrapped_live: got valid=%b pc=%h expected valid=1 pc=00000500", pc_valid_o, pc_o); end
    resp_valid_i = 1'b0;
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    req_ready_i = 1'b1;
    cyc();
    resp_valid_i = 1'b1;
    cyc();
    tests_run++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL frz_pre: got valid=%b pc=%h expected valid=1 pc=00000000", pc_valid_o, pc_o); end
    rdy = 1'b0;
    #1;
    tests_run++; if (req_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL frz_req_valid: got %b expected 0", req_valid_o); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests_run++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h0 || req_pc_o !== 32'h8) begin tests_failed++; $display("[TB] FAIL frz_hold i=%0d: got valid=%b pc_o=%h req_pc=%h expected valid=1 pc_o=00000000 req_pc=00000008", i, pc_valid_o, pc_o, req_pc_o); end
    end
    rdy = 1'b1;
    #1;
    tests_run++; if (req_valid_o !== 1'b1 || req_pc_o !== 32'h8) begin tests_failed++; $display("[TB] FAIL frz_resume_req: got valid=%b pc=%h expected valid=1 pc=00000008", req_valid_o, req_pc_o); end
    cyc();
    tests_run++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h4) begin tests_failed++; $display("[TB] FAIL frz_resume_resp: got valid=%b pc=%h expected valid=1 pc=00000004", pc_valid_o, pc_o); end
    req_ready_i = 1'b0; resp_valid_i = 1'b0;
    cyc();
    tests_run++; if (pc_valid_o !== 1'b0 || pc_o !== 32'h4) begin tests_failed++; $display("[TB] FAIL frz_after: got valid=%b pc=%h expected valid=0 pc=00000004", pc_valid_o, pc_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_ready_i = 1'b1;
    cyc();
    cyc();
    rst = 1'b1; resp_valid_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h700;
    #1;
    tests_run++; if (req_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_req_valid: got %b expected 0", req_valid_o); end
    cyc();
    rst = 1'b0; redirect_i = 1'b0; req_ready_i = 1'b0;
    #1;
    tests_run++; if (req_pc_o !== 32'h0 || req_epoch_o !== 2'd0) begin tests_failed++; $display("[TB] FAIL rstmid_state: got pc=%h epoch=%0d expected pc=00000000 epoch=0", req_pc_o, req_epoch_o); end
    tests_run++; if (pc_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_pc_valid: got %b expected 0", pc_valid_o); end
    cyc();
    tests_run++; if (pc_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_stray_a: got %b expected 0", pc_valid_o); end
    cyc();
    tests_run++; if (pc_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_stray_b: got %b expected 0", pc_valid_o); end
    resp_valid_i = 1'b0; req_ready_i = 1'b1;
    #1;
    tests_run++; if (req_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_empty0: got %b expected 1", req_valid_o); end
    cyc();
    tests_run++; if (req_valid_o !== 1'b1 || req_pc_o !== 32'h4) begin tests_failed++; $display("[TB] FAIL rstmid_empty1: got valid=%b pc=%h expected valid=1 pc=00000004", req_valid_o, req_pc_o); end
    cyc();
    tests_run++; if (req_valid_o !== 1'b0 || req_pc_o !== 32'h8) begin tests_failed++; $display("[TB] FAIL rstmid_refill: got valid=%b pc=%h expected valid=0 pc=00000008", req_valid_o, req_pc_o); end
    req_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_stream();
    test_redirect();
    test_max_outstanding();
    test_redirect_resp();
    test_rdy_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- ADDR_LEN, 32, PC width.
- RESET_VEC, 0, PC after reset.
- STEP, 4, PC increment per issued fetch.
- MAX_OUT, 2, max outstanding fetches; power of two, >=2.
- EPOCH_W, 2, redirect-epoch tag width.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous, active-high reset.
- rdy, in, 1, global enable; low freezes the block.
- stall_i, in, 1, suppress new fetch issue.
- redirect_i, in, 1, jump/flush request.
- redirect_pc_i, in, ADDR_LEN, redirect target.
- req_valid_o, out, 1, fetch request valid.
- req_ready_i, in, 1, memory accepts request.
- req_pc_o, out, ADDR_LEN, fetch address.
- req_epoch_o, out, EPOCH_W, epoch tag of request.
- resp_valid_i, in, 1, fetch response returned, in order.
- pc_valid_o, out, 1, one-cycle pulse: a live fetch completed.
- pc_o, out, ADDR_LEN, PC of the completed live fetch.

Function
REQ-003 Internal state SHALL be: fetch PC, epoch counter, and a FIFO of {pc, epoch} entries of depth MAX_OUT.
- Occupancy count SHALL have width clog2(MAX_OUT)+1.

REQ-004 req_valid_o SHALL equal rdy & !rst & !stall_i & !redirect_i & (count < MAX_OUT), combinationally.

REQ-005 req_pc_o and req_epoch_o SHALL be the current fetch PC and epoch, combinationally.

REQ-006 On handshake (req_valid_o & req_ready_i), the block SHALL push {pc, epoch} and advance PC by STEP modulo 2^ADDR_LEN.

REQ-007 On redirect_i & rdy, the block SHALL:
- load PC with redirect_pc_i;
- increment epoch, wrapping at 2^EPOCH_W;
- issue no request that cycle.

REQ-008 On resp_valid_i & rdy with FIFO non-empty, the block SHALL pop the head entry.
- If the entry's epoch equals the current epoch and redirect_i is low, pc_o SHALL be the entry pc and pc_valid_o SHALL be 1 on the next cycle.
- Otherwise the response SHALL be dropped silently.

REQ-009 A response arriving in the same cycle as redirect_i SHALL always be dropped.

REQ-010 resp_valid_i with an empty FIFO SHALL be ignored, with no state change.

REQ-011 A simultaneous push and pop SHALL leave count unchanged; the FIFO pointers SHALL wrap modulo MAX_OUT.

REQ-012 Latency SHALL be exactly one cycle from resp_valid_i to pc_valid_o. pc_valid_o SHALL be low in every other cycle, and pc_o SHALL hold its last value.

REQ-013 When rdy is low, all registers SHALL hold and resp_valid_i SHALL be ignored; pc_valid_o SHALL hold its current value.

REQ-014 Stale-epoch entries SHALL still occupy FIFO slots until their responses return.

Reset
REQ-015 While rst is high at a clock edge, the block SHALL set:
- PC = RESET_VEC, epoch = 0;
- FIFO pointers and count = 0;
- pc_o = 0, pc_valid_o = 0.

REQ-016 rst SHALL take priority over rdy, redirect_i and all handshakes; a reset mid-operation SHALL discard all outstanding entries.

REQ-017 Responses for fetches issued before reset SHALL be ignored under REQ-010 once the FIFO is empty.

Structure
REQ-018 AddrLen and ZERO_WORD SHALL come from the shared config header. Parameter defaults SHALL reference AddrLen; no new global defines.

REQ-019 The {pc, epoch} queue SHALL be a sub-module pc_tag_fifo, parameterised by width and depth, with push/pop/full/empty.

REQ-020 The epoch comparison and redirect priority logic SHALL reside in pc_fetch_ctrl.

Verification
REQ-021 Reset, then req_ready_i=1, stall_i=0, resp delayed 1 cycle -> req_pc_o = 0, 4, 8, ...; pc_o follows at 0, 4, 8 with pc_valid_o pulses.

REQ-022 Issue 0 and 4, then redirect_pc_i=0x100 before their responses -> both responses dropped; next request is 0x100 with epoch 1; first pc_o = 0x100.

REQ-023 req_ready_i=1, no responses -> exactly MAX_OUT=2 requests (0, 4); then req_valid_o stays 0 until one response, then a request at 8 issues.

REQ-024 Response at the same edge as redirect_i -> no pc_valid_o pulse; count decremented; epoch wraps 3 -> 0 after four redirects.

REQ-025 rdy=0 for 3 cycles mid-stream with resp_valid_i=1 -> no state change; stream resumes unchanged when rdy=1.

REQ-026 rst asserted with 2 outstanding fetches -> PC = RESET_VEC, count = 0; subsequent stray resp_valid_i ignored.
